// File: rtl/approx_adder_pipe.sv
// Pipelined ripple adder whose low APPROX_BITS cells can run as approximate
// (sum = NOT carry) cells, with a parallel exact reference and error counter.
module approx_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 4,
    parameter int STAGES      = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // One carry-chain segment covering bits [lo, hi); bits outside pass through.
    function automatic logic [WIDTH:0] seg_add(
        input logic [WIDTH-1:0] s_in,
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic             c_in,
        input logic             apx,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] s;
        logic             c;
        logic             m;
        s = s_in;
        c = c_in;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= lo && i < hi) begin
                m    = maj3(op_a[i], op_b[i], c);
                s[i] = (apx && i < APPROX_BITS) ? ~m : (op_a[i] ^ op_b[i] ^ c);
                c    = m;
            end
        end
        return {c, s};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             en;
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];
    logic             x_d   [STAGES];
    logic [WIDTH:0]   r_d   [STAGES];
    logic [WIDTH:0]   nxt   [STAGES];

    logic [WIDTH-1:0] a_p   [NREG];
    logic [WIDTH-1:0] b_p   [NREG];
    logic [WIDTH-1:0] s_p   [NREG];
    logic             c_p   [NREG];
    logic             x_p   [NREG];
    logic [WIDTH:0]   r_p   [NREG];
    logic [STAGES-1:0] vld_p;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    assign en        = !vld_p[STAGES-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p[STAGES-1];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_err   = err_q;
    assign err_cnt   = cnt_q;

    always_comb begin
        a_d[0] = a;
        b_d[0] = b;
        s_d[0] = '0;
        c_d[0] = cin;
        x_d[0] = approx_en;
        r_d[0] = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_p[k-1];
            b_d[k] = b_p[k-1];
            s_d[k] = s_p[k-1];
            c_d[k] = c_p[k-1];
            x_d[k] = x_p[k-1];
            r_d[k] = r_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            nxt[k] = seg_add(s_d[k], a_d[k], b_d[k], c_d[k], x_d[k], k * SEG,
                             ((k + 1) * SEG > WIDTH) ? WIDTH : (k + 1) * SEG);
        end
    end

    // Stage boundaries: segment k result lands in register k; the last segment
    // lands directly in the output registers.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_p[k] <= a_d[k];
                b_p[k] <= b_d[k];
                s_p[k] <= nxt[k][WIDTH-1:0];
                c_p[k] <= nxt[k][WIDTH];
                x_p[k] <= x_d[k];
                r_p[k] <= r_d[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (en) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            sum_q  <= nxt[STAGES-1][WIDTH-1:0];
            cout_q <= nxt[STAGES-1][WIDTH];
            err_q  <= (nxt[STAGES-1] != r_d[STAGES-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (vld_p[STAGES-1] && out_ready && err_q) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Scoreboard bench for approx_adder_pipe (WIDTH=8, APPROX_BITS=2, STAGES=2, CNT_W=4).
module tb_approx_adder_pipe;

    localparam int W  = 8;
    localparam int AB = 2;
    localparam int ST = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          approx_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          out_err;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] err_cnt;

    approx_adder_pipe #(.WIDTH(W), .APPROX_BITS(AB), .STAGES(ST), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .out_err(out_err), .cnt_clr(cnt_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_out   = 0;
    logic [W+1:0]  exp_q[$];
    logic [W+1:0]  e;
    logic [CW-1:0] exp_cnt = '0;
    bit            rand_rdy = 1'b0;
    bit            force_rdy = 1'b1;
    bit            stalled = 1'b0;
    logic [W-1:0]  hold_sum;
    logic          hold_cout;
    logic          hold_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Expected {err, cout, sum}: approximate low cells, exact upper bits fed
    // with the approximate-chain carry, compared against the plain sum.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic mx);
        logic [W-1:0]  s;
        logic          c;
        logic          m;
        logic [W-AB:0] hi;
        logic [W:0]    ex;
        c = mc;
        s = '0;
        for (int i = 0; i < AB; i++) begin
            m    = (ma[i] & mb[i]) | (ma[i] & c) | (mb[i] & c);
            s[i] = mx ? ~m : (ma[i] ^ mb[i] ^ c);
            c    = m;
        end
        hi = {1'b0, ma[W-1:AB]} + {1'b0, mb[W-1:AB]} + {{(W-AB){1'b0}}, c};
        s[W-1:AB] = hi[W-AB-1:0];
        ex = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        return {({hi[W-AB], s} != ex), hi[W-AB], s};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
            exp_cnt = '0;
        end else begin
            check("err_cnt", err_cnt, exp_cnt);
            if (stalled && out_valid) begin
                check("hold_sum", sum, hold_sum);
                check("hold_cout", cout, hold_cout);
                check("hold_err", out_err, hold_err);
            end
            if (out_valid && !out_ready) begin
                check("in_ready_stall", in_ready, 0);
                stalled   = 1'b1;
                hold_sum  = sum;
                hold_cout = cout;
                hold_err  = out_err;
            end else begin
                stalled = 1'b0;
            end
            e = '0;
            if (out_valid && out_ready) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_out++;
                    check("sum", sum, e[W-1:0]);
                    check("cout", cout, e[W]);
                    check("out_err", out_err, e[W+1]);
                end
            end
            if (cnt_clr) exp_cnt = '0;
            else if (e[W+1] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic tx);
        int  n = 0;
        bit  ok = 1'b0;
        a = ta; b = tb_; cin = tc; approx_en = tx; in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(ta, tb_, tc, tx));
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
            n++;
        end
        check("send_accept", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("out_seen", out_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic stall_ctl();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        force_rdy = 1'b0;
        repeat (3) @(negedge clk);
        force_rdy = 1'b1;
    endtask

    initial begin
        int lat;
        int base;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        send(8'h00, 8'h00, 1'b0, 1'b1);
        wait_out(lat);
        check("latency", lat, ST);
        check("r22_sum", sum, 8'h03);
        check("r22_cout", cout, 0);
        check("r22_err", out_err, 1);
        drain();
        check("r22_cnt", err_cnt, 1);

        send(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_out(lat);
        check("r23a_sum", sum, 8'h00);
        check("r23a_cout", cout, 1);
        check("r23a_err", out_err, 0);
        drain();
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_out(lat);
        check("r23b_sum", sum, 8'h00);
        check("r23b_cout", cout, 1);
        check("r23b_err", out_err, 0);
        drain();

        base = n_out;
        fork
            begin
                send(8'h12, 8'h34, 1'b0, 1'b1);
                send(8'hA5, 8'h5A, 1'b1, 1'b1);
                send(8'h7F, 8'h01, 1'b1, 1'b0);
                send(8'h03, 8'h03, 1'b0, 1'b1);
            end
            stall_ctl();
        join
        drain();
        check("r24_delivered", n_out - base, 4);

        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        repeat (20) send(8'h00, 8'h00, 1'b0, 1'b1);
        drain();
        check("r25_sat", err_cnt, 15);
        cnt_clr = 1'b1;
        send(8'h00, 8'h00, 1'b0, 1'b1);
        drain();
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        check("r25_clr", err_cnt, 0);

        send(8'h00, 8'h00, 1'b0, 1'b1);
        drain();
        check("r26_pre_cnt", err_cnt, 1);
        send(8'h55, 8'h0F, 1'b1, 1'b1);
        send(8'h80, 8'h80, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("r26_out_valid", out_valid, 0);
        check("r26_err_cnt", err_cnt, 0);
        check("r26_in_ready", in_ready, 1);
        check("r26_sum", sum, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("r26_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        rand_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
